dcm_prog_ctrl: RTL and testbench

//  Upstream front end of the dcm clock generator; runs on the 100 MHz clock.

---
 rtl/dcm_prog_ctrl_if.sv | 23 ++
 rtl/dcm_prog_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_dcm_prog_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcm_prog_ctrl_if.sv
// Bundle of the button, program and handshake signals between the board-side
// driver (master) and dcm_prog_ctrl (slave).
interface dcm_prog_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_apply;
    logic [2:0] prog_cur;
    logic [2:0] prog_in;
    logic       update;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output btn_up, btn_down, btn_apply, prog_cur,
        input  prog_in, update, busy, done, err
    );

    modport slave (
        input  btn_up, btn_down, btn_apply, prog_cur,
        output prog_in, update, busy, done, err
    );
endinterface

// File: rtl/dcm_prog_ctrl.sv
// dcm_prog_ctrl: push-button front end for the dcm clock generator.
// Debounces up/down/apply, keeps a pending program 0..7 and holds update high
// until dcm reports the new program (or a timeout moves it to ERR).
// Optional feature macro: PROG_WRAP_EN (modulo-8 up/down instead of saturating).

// Per-button path: 2-FF synchronizer, stability counter, rising-edge strobe.
module dcm_prog_debounce #(
    parameter int DEBOUNCE_CNT = 1_000_000,
    parameter int CNT_W        = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    logic [1:0]       sync;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b00;
        else      sync <= {sync[0], raw};
    end

    // Accept a new level only after it stayed stable for DEBOUNCE_CNT cycles;
    // any return to the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync[1] == level) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Delayed copy of the accepted level for press-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) level_d <= 1'b0;
        else      level_d <= level;
    end

    assign press = level & ~level_d;
endmodule

module dcm_prog_ctrl #(
    parameter int DEBOUNCE_CNT = 1_000_000,
    parameter int ACK_TIMEOUT  = 200_000_000,
    parameter int CNT_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    dcm_prog_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

    localparam int NUM_BTN = 3;
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_APPLY = 2;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_press;

    state_t           state, state_nxt;
    logic [2:0]       prog_q, prog_nxt, prog_adj;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic             update_q, busy_q, done_q, err_q;
    logic             done_nxt;
    logic             up_s, down_s, apply_s;

    assign btn_raw = {bus.btn_apply, bus.btn_down, bus.btn_up};

    // One debouncer per button.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        dcm_prog_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .CNT_W        (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .press (btn_press[i])
        );
    end

    assign up_s    = btn_press[B_UP];
    assign down_s  = btn_press[B_DOWN];
    assign apply_s = btn_press[B_APPLY];

    // Candidate program after this cycle's up/down strobes; simultaneous
    // up and down cancel out.
    always_comb begin
        prog_adj = prog_q;
        if (up_s && !down_s) begin
`ifdef PROG_WRAP_EN
            prog_adj = prog_q + 3'd1;
`else
            if (prog_q != 3'd7) prog_adj = prog_q + 3'd1;
`endif
        end else if (down_s && !up_s) begin
`ifdef PROG_WRAP_EN
            prog_adj = prog_q - 3'd1;
`else
            if (prog_q != 3'd0) prog_adj = prog_q - 3'd1;
`endif
        end
    end

    // Next state, program and timer. Apply is evaluated against the
    // already-adjusted program; strobes seen in REQ are dropped.
    always_comb begin
        state_nxt = state;
        prog_nxt  = prog_q;
        timer_nxt = timer;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                prog_nxt = prog_adj;
                if (apply_s && prog_adj != bus.prog_cur) begin
                    state_nxt = REQ;
                    timer_nxt = '0;
                end
            end
            REQ: begin
                if (bus.prog_cur == prog_q) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    timer_nxt = '0;
                end else if (timer == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_nxt = ERR;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            ERR: begin
                prog_nxt = prog_adj;
                if (apply_s) begin
                    state_nxt = (prog_adj == bus.prog_cur) ? IDLE : REQ;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // State, program, timer and registered outputs; async reset drops
    // update without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            prog_q   <= 3'd0;
            timer    <= '0;
            update_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            prog_q   <= prog_nxt;
            timer    <= timer_nxt;
            update_q <= (state_nxt == REQ);
            busy_q   <= (state_nxt == REQ);
            done_q   <= done_nxt;
            err_q    <= (state_nxt == ERR);
        end
    end

    assign bus.prog_in = prog_q;
    assign bus.update  = update_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Bench for dcm_prog_ctrl with DEBOUNCE_CNT=4, ACK_TIMEOUT=20: directed
// scenarios followed by random button/apply sequences against a simple model.
module tb_dcm_prog_ctrl;
    localparam int DB   = 4;
    localparam int TMO  = 20;
    localparam int HOLD = DB + 6;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_prog = 0;
    bit   exp_err  = 1'b0;

    dcm_prog_ctrl_if bus ();

    dcm_prog_ctrl #(
        .DEBOUNCE_CNT (DB),
        .ACK_TIMEOUT  (TMO),
        .CNT_W        (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of the pending program: plain integer arithmetic, clamped or wrapped.
    function automatic int next_prog(input int p, input bit up, input bit dn);
        int v = p;
        if (up && !dn) v = v + 1;
        if (dn && !up) v = v - 1;
`ifdef PROG_WRAP_EN
        v = (v + 8) % 8;
`else
        if (v > 7) v = 7;
        if (v < 0) v = 0;
`endif
        return v;
    endfunction

    task automatic press(input bit up, input bit dn);
        bus.btn_up   = up;
        bus.btn_down = dn;
        repeat (HOLD) step();
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        repeat (HOLD) step();
        exp_prog = next_prog(exp_prog, up, dn);
        chk("prog_after_press", 32'(bus.prog_in), 32'(exp_prog));
        chk("err_after_press", 32'(bus.err), 32'(exp_err));
    endtask

    // Apply with prog_cur=cur. ack_delay<0 lets the request time out;
    // poke_up presses up while the request is outstanding (must be ignored).
    task automatic apply(input int cur, input int ack_delay, input bit poke_up);
        int  n;
        bit  seen_busy, seen_done;
        bus.prog_cur  = 3'(cur);
        bus.btn_apply = 1'b1;
        if (exp_prog != cur) begin
            n = 0;
            while (!bus.busy && n < 15) begin
                step();
                n++;
            end
            chk("req_entry_busy", 32'(bus.busy), 32'd1);
            chk("req_entry_update", 32'(bus.update), 32'd1);
            chk("req_entry_err", 32'(bus.err), 32'd0);
            if (ack_delay >= 0) begin
                repeat (ack_delay) step();
                bus.prog_cur = 3'(exp_prog);
                step();
                chk("ack_busy", 32'(bus.busy), 32'd0);
                chk("ack_update", 32'(bus.update), 32'd0);
                chk("ack_done", 32'(bus.done), 32'd1);
                step();
                chk("done_one_cycle", 32'(bus.done), 32'd0);
                exp_err = 1'b0;
            end else begin
                n = 1;
                seen_done = 1'b0;
                while (n < 100) begin
                    if (poke_up && n == 1)  bus.btn_up = 1'b1;
                    if (poke_up && n == 10) bus.btn_up = 1'b0;
                    step();
                    seen_done |= bus.done;
                    if (!bus.busy) break;
                    n++;
                end
                bus.btn_up = 1'b0;
                chk("timeout_cycles", 32'(n), 32'(TMO));
                chk("timeout_err", 32'(bus.err), 32'd1);
                chk("timeout_update", 32'(bus.update), 32'd0);
                chk("timeout_no_done", 32'(seen_done), 32'd0);
                exp_err = 1'b1;
            end
        end else begin
            seen_busy = 1'b0;
            seen_done = 1'b0;
            repeat (HOLD) begin
                step();
                seen_busy |= bus.busy;
                seen_done |= bus.done;
            end
            chk("apply_equal_no_req", 32'(seen_busy), 32'd0);
            chk("apply_equal_no_done", 32'(seen_done), 32'd0);
            exp_err = 1'b0;
        end
        bus.btn_apply = 1'b0;
        repeat (HOLD) step();
        chk("prog_after_apply", 32'(bus.prog_in), 32'(exp_prog));
        chk("err_after_apply", 32'(bus.err), 32'(exp_err));
        chk("busy_after_apply", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        rst           = 1'b0;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_apply = 1'b0;
        bus.prog_cur  = 3'd0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // Reset state.
        chk("rst_prog", 32'(bus.prog_in), 32'd0);
        chk("rst_update", 32'(bus.update), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);

        // Bouncing up press gives exactly one increment.
        bus.btn_up = 1'b1; step();
        bus.btn_up = 1'b0; step();
        bus.btn_up = 1'b1;
        repeat (HOLD) step();
        bus.btn_up = 1'b0;
        repeat (HOLD) step();
        exp_prog = 1;
        chk("bounce_single_strobe", 32'(bus.prog_in), 32'd1);

        // Acknowledged request 3 -> dcm, ack 5 cycles after update.
        press(1, 0);
        press(1, 0);
        apply(0, 5, 0);

        // Timed-out request at 5, up press during REQ discarded, then retry.
        press(1, 0);
        press(1, 0);
        apply(0, -1, 1);
        press(0, 1);
        press(1, 0);
        apply(0, 3, 0);

        // Boundaries: down at 0, then eight ups.
        while (exp_prog != 0) press(0, 1);
        press(0, 1);
        repeat (8) press(1, 0);

        // up+down together leave the program alone.
        press(1, 1);

        // Async reset while update is high.
        if (exp_prog == 0) press(1, 0);
        bus.prog_cur  = 3'(exp_prog + 1);
        bus.btn_apply = 1'b1;
        n = 0;
        while (!bus.update && n < 15) begin
            step();
            n++;
        end
        chk("pre_reset_update", 32'(bus.update), 32'd1);
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_update", 32'(bus.update), 32'd0);
        chk("async_reset_prog", 32'(bus.prog_in), 32'd0);
        bus.btn_apply = 1'b0;
        step();
        rst = 1'b1;
        exp_prog = 0;
        exp_err  = 1'b0;
        bus.prog_cur = 3'd0;
        repeat (HOLD) step();
        chk("post_reset_busy", 32'(bus.busy), 32'd0);

        // Random sequences against the model.
        for (int i = 0; i < 40; i++) begin
            int r, cur, mode;
            r = int'($urandom_range(0, 4));
            case (r)
                0, 1: press(1, 0);
                2:    press(0, 1);
                3:    press(1, 1);
                default: begin
                    cur  = int'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) == 0) cur = exp_prog;
                    mode = int'($urandom_range(0, 2));
                    apply(cur, (mode == 0) ? -1 : int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
